// File: rtl/arb_mux_rr.sv
// arb_mux_rr: N-input, W-bit registered merge point with valid/ready handshakes.
// One requesting channel is granted per cycle (round-robin or fixed priority),
// and the winning word is registered together with its source index.
module arb_mux_rr #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = 0,
    localparam int SELW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_sel,
    input  logic            out_ready
);

    logic [SELW-1:0] ptr;
    logic [N-1:0]    hi_mask;
    logic [N-1:0]    req_hi;
    logic [N-1:0]    req_sel;
    logic [N-1:0]    grant;
    logic [SELW-1:0] gidx;
    logic [W-1:0]    gdata;
    logic            found;
    logic            load_en;
    logic            take;

    // Round-robin window: channels at or above ptr are searched first; fixed
    // priority leaves the window empty so the plain lowest-index search wins.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (MODE == 0) && (i >= int'(ptr));
        end
    end

    assign req_hi  = in_valid & hi_mask;
    assign req_sel = (|req_hi) ? req_hi : in_valid;

    // Lowest-index pick from the selected request set yields a one-hot grant.
    always_comb begin
        grant = '0;
        gidx  = '0;
        gdata = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_sel[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gidx     = SELW'(i);
                gdata    = in_data[i*W +: W];
            end
        end
    end

    assign load_en  = ~out_valid | out_ready;
    assign in_ready = rst ? '0 : (grant & {N{load_en}});
    assign take     = |in_ready;

    // Output register and round-robin pointer; a new word may replace one
    // being drained in the same cycle, so throughput is one word per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= gdata;
            out_sel   <= gidx;
            ptr       <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux_rr.sv
// tb_arb_mux_rr: directed checks of arb_mux_rr in round-robin and fixed
// priority modes, plus a scoreboarded random run at N=2/W=1 and N=16/W=32.
module tb_arb_mux_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Round-robin instance, N=4 W=8
    logic [3:0]  v, ir;
    logic [31:0] d;
    logic        ordy, ov;
    logic [7:0]  od;
    logic [1:0]  os;

    // Fixed-priority instance, N=4 W=8
    logic [3:0]  fv, fir;
    logic [31:0] fd;
    logic        fordy, fov;
    logic [7:0]  fod;
    logic [1:0]  fos;

    // Sweep instance N=2 W=1
    logic [1:0]  s2v, s2ir, s2d;
    logic        s2r, s2ov;
    logic [0:0]  s2od, s2os;

    // Sweep instance N=16 W=32
    logic [15:0]  s16v, s16ir;
    logic [511:0] s16d;
    logic         s16r, s16ov;
    logic [31:0]  s16od;
    logic [3:0]   s16os;

    arb_mux_rr #(.N(4), .W(8), .MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(v), .in_data(d), .in_ready(ir),
        .out_valid(ov), .out_data(od), .out_sel(os), .out_ready(ordy));

    arb_mux_rr #(.N(4), .W(8), .MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .in_valid(fv), .in_data(fd), .in_ready(fir),
        .out_valid(fov), .out_data(fod), .out_sel(fos), .out_ready(fordy));

    arb_mux_rr #(.N(2), .W(1), .MODE(0)) dut_s2 (
        .clk(clk), .rst(rst), .in_valid(s2v), .in_data(s2d), .in_ready(s2ir),
        .out_valid(s2ov), .out_data(s2od), .out_sel(s2os), .out_ready(s2r));

    arb_mux_rr #(.N(16), .W(32), .MODE(0)) dut_s16 (
        .clk(clk), .rst(rst), .in_valid(s16v), .in_data(s16d), .in_ready(s16ir),
        .out_valid(s16ov), .out_data(s16od), .out_sel(s16os), .out_ready(s16r));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] qd[$];
    int          qs[$];
    int          m2, m16, g, idx;
    logic [15:0] exp_ir;
    logic [31:0] exp_d;
    int          exp_s;

    initial begin
        v = '0; d = 32'hA3A2A1A0; ordy = 1'b0;
        fv = '0; fd = 32'hD3D2D1D0; fordy = 1'b0;
        s2v = '0; s2d = '0; s2r = 1'b0;
        s16v = '0; s16d = '0; s16r = 1'b0;

        // Reset state
        #2;
        chk("rst_ov", ov, 0);
        chk("rst_od", od, 0);
        chk("rst_os", os, 0);
        chk("rst_ptr", dut_rr.ptr, 0);
        v = 4'hF; ordy = 1'b1;
        #1;
        chk("rst_ready_forced", ir, 0);
        step();
        chk("rst_no_transfer", ov, 0);

        // Round-robin sequence 0,1,2,3,0
        rst = 1'b0;
        #1;
        chk("rr_first_ready", ir, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_ov", ov, 1);
            chk("rr_sel", os, k % 4);
            chk("rr_data", od, 8'hA0 + (k % 4));
        end
        chk("rr_ptr_after", dut_rr.ptr, 1);

        // Backpressure holding 8'h5C from channel 1
        d = 32'hA3A25CA0;
        step();
        chk("bp_load_data", od, 8'h5C);
        chk("bp_load_sel", os, 1);
        chk("bp_load_ptr", dut_rr.ptr, 2);
        ordy = 1'b0;
        #1;
        chk("bp_ready_low", ir, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_ov", ov, 1);
            chk("bp_hold_data", od, 8'h5C);
            chk("bp_hold_sel", os, 1);
            chk("bp_hold_ptr", dut_rr.ptr, 2);
            chk("bp_hold_ready", ir, 0);
        end
        ordy = 1'b1;
        #1;
        chk("bp_release_ready", ir, 4'b0100);
        step();
        chk("bp_next_data", od, 8'hA2);
        chk("bp_next_sel", os, 2);
        chk("bp_next_ov", ov, 1);
        chk("bp_next_ptr", dut_rr.ptr, 3);

        // Sparse requests and wrap
        d = 32'hA3B2A1A0;
        v = 4'b0100;
        #1;
        chk("sp_ready_ch2", ir, 4'b0100);
        step();
        chk("sp_sel_ch2", os, 2);
        chk("sp_data_ch2", od, 8'hB2);
        chk("sp_ptr3", dut_rr.ptr, 3);
        v = 4'b0001;
        #1;
        chk("sp_ready_ch0", ir, 4'b0001);
        step();
        chk("sp_sel_ch0", os, 0);
        chk("sp_data_ch0", od, 8'hA0);
        chk("sp_ptr1", dut_rr.ptr, 1);
        v = 4'b0000;
        #1;
        chk("sp_ready_none", ir, 0);
        step();
        chk("drain_ov", ov, 0);
        chk("drain_data_hold", od, 8'hA0);

        // Asynchronous reset mid-transfer
        d = 32'hA3A2A1A0;
        v = 4'hF;
        step();
        chk("mid_ov", ov, 1);
        chk("mid_sel", os, 1);
        chk("mid_data", od, 8'hA1);
        ordy = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("async_ov", ov, 0);
        chk("async_od", od, 0);
        chk("async_os", os, 0);
        chk("async_ptr", dut_rr.ptr, 0);
        chk("async_ready", ir, 0);
        #2;
        rst = 1'b0;
        ordy = 1'b1;
        #1;
        chk("post_rst_ready", ir, 4'b0001);
        step();
        chk("post_rst_sel", os, 0);
        chk("post_rst_data", od, 8'hA0);
        v = '0;

        // Fixed priority: channels 1 and 3 requesting
        fv = 4'b1010; fordy = 1'b1;
        #1;
        chk("fp_ready", fir, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("fp_sel", fos, 1);
            chk("fp_data", fod, 8'hD1);
            chk("fp_ready_hold", fir, 4'b0010);
        end
        fordy = 1'b0;
        #1;
        chk("fp_bp_ready", fir, 0);
        fv = 4'b1000; fordy = 1'b1;
        #1;
        chk("fp_ch3_ready", fir, 4'b1000);
        step();
        chk("fp_ch3_sel", fos, 3);
        chk("fp_ch3_data", fod, 8'hD3);
        fv = '0;

        // Random sweep N=2 W=1
        m2 = 0;
        for (int c = 0; c < 300; c++) begin
            s2v = 2'($urandom);
            s2d = 2'($urandom);
            s2r = 1'($urandom_range(0, 1));
            #1;
            g = -1;
            for (int k = 0; k < 2; k++) begin
                idx = (m2 + k) % 2;
                if (g < 0 && s2v[idx]) g = idx;
            end
            exp_ir = '0;
            if (g >= 0 && !(qd.size() != 0 && !s2r)) exp_ir = 16'(1) << g;
            chk("s2_ready", s2ir, exp_ir[1:0]);
            chk("s2_occ", s2ov, qd.size() != 0);
            if (qd.size() != 0 && s2r) begin
                exp_d = qd.pop_front();
                exp_s = qs.pop_front();
                chk("s2_data", s2od, exp_d[0]);
                chk("s2_sel", s2os, exp_s);
            end
            if (exp_ir != 0) begin
                qd.push_back({31'b0, s2d[g]});
                qs.push_back(g);
                m2 = (g + 1) % 2;
            end
            step();
        end
        s2v = '0; s2r = 1'b1;
        qd.delete(); qs.delete();
        step();
        chk("s2_drained", s2ov, 0);

        // Random sweep N=16 W=32
        m16 = 0;
        for (int c = 0; c < 300; c++) begin
            s16v = (c % 7 == 0) ? 16'hFFFF : 16'($urandom);
            for (int i = 0; i < 16; i++) s16d[i*32 +: 32] = $urandom;
            s16r = 1'($urandom_range(0, 1));
            #1;
            g = -1;
            for (int k = 0; k < 16; k++) begin
                idx = (m16 + k) % 16;
                if (g < 0 && s16v[idx]) g = idx;
            end
            exp_ir = '0;
            if (g >= 0 && !(qd.size() != 0 && !s16r)) exp_ir = 16'(1) << g;
            chk("s16_ready", s16ir, exp_ir);
            chk("s16_occ", s16ov, qd.size() != 0);
            if (qd.size() != 0 && s16r) begin
                exp_d = qd.pop_front();
                exp_s = qs.pop_front();
                chk("s16_data", s16od, exp_d);
                chk("s16_sel", s16os, exp_s);
            end
            if (exp_ir != 0) begin
                qd.push_back(s16d[g*32 +: 32]);
                qs.push_back(g);
                m16 = (g + 1) % 16;
            end
            step();
        end
        s16v = '0; s16r = 1'b1;
        step();
        chk("s16_drained", s16ov, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
